gate_bist_ctrl: RTL and testbench

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl.sv | 137 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// Built-in self test for a 2-input gate: walks {A,B} through 00..11, waits SETTLE
// cycles per vector, compares Y against the TRUTH table and reports per-vector failures.
//
// state  | meaning
// IDLE   | waiting for START, results of the last run held
// APPLY  | new vector on {A,B}, settle counter loaded
// SETTLE | gate output settling, counter running down
// CHECK  | Y compared with the expected truth-table bit
// FINISH | DONE pulse, PASS updated, {A,B} returned to 00
module gate_bist_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [3:0] TRUTH  = 4'b1001
) (
  input  logic       CLK,
  input  logic       N_RESET,
  input  logic       START,
  input  logic       ABORT,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [2:0] ERR_CNT,
  output logic [3:0] FAIL_VEC
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fv_q, fv_d;
  logic       pass_q, pass_d;
  logic       abort_run;

  assign abort_run = ABORT && (state_q != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ab_q    <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      fv_q    <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = S_APPLY;
      S_APPLY:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_CHECK;
      S_CHECK:  state_d = (idx_q == 2'd3) ? S_FINISH : S_APPLY;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_run) state_d = S_IDLE;
  end

  // The vector is placed on {A,B} when APPLY is entered so it is stable for the whole slot.
  always_comb begin
    idx_d  = idx_q;
    ab_d   = ab_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fv_d   = fv_q;
    pass_d = pass_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          idx_d  = 2'd0;
          ab_d   = 2'd0;
          err_d  = 3'd0;
          fv_d   = 4'd0;
          pass_d = 1'b0;
        end
      end
      S_APPLY:  cnt_d = SETTLE_LOAD;
      S_SETTLE: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      S_CHECK: begin
        if (Y != TRUTH[idx_q]) begin
          if (err_q < 3'd4) err_d = err_q + 3'd1;
          fv_d[idx_q] = 1'b1;
        end
        if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
          ab_d  = idx_q + 2'd1;
        end
      end
      S_FINISH: begin
        pass_d = (err_q == 3'd0);
        ab_d   = 2'd0;
      end
      default: ;
    endcase
    // Abort keeps the partial error record but discards any result of this cycle's CHECK.
    if (abort_run) begin
      ab_d   = 2'd0;
      pass_d = 1'b0;
      err_d  = err_q;
      fv_d   = fv_q;
    end
  end

  always_comb begin
    A        = ab_q[1];
    B        = ab_q[0];
    BUSY     = (state_q != S_IDLE);
    DONE     = (state_q == S_FINISH);
    PASS     = pass_q;
    ERR_CNT  = err_q;
    FAIL_VEC = fv_q;
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (NXOR/SETTLE=2 and XOR/SETTLE=1) driven by random
// runs, aborts and resets; a run-level reference model feeds a DONE scoreboard.
module tb_gate_bist_ctrl;

  localparam int         S0 = 2;
  localparam int         S1 = 1;
  localparam logic [3:0] T0 = 4'b1001;
  localparam logic [3:0] T1 = 4'b0110;
  localparam int         L0 = 4 * (S0 + 2);

  typedef struct {
    int         due;
    logic [2:0] err;
    logic [3:0] fv;
  } done_t;

  logic       clk = 1'b0;
  logic       n_reset, start, abort;
  logic [1:0] y_s, a_s, b_s, busy_s, done_s, pass_s;
  logic [2:0] err_s [2];
  logic [3:0] fv_s  [2];
  logic [3:0] tbl   [2];

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  bit         act    [2];
  int         st     [2];
  logic [3:0] run_tbl[2];
  logic [1:0] m_ab   [2];
  logic       m_busy [2];
  logic       m_pass [2];
  logic [2:0] m_err  [2];
  logic [3:0] m_fv   [2];
  done_t      q0[$];
  done_t      q1[$];

  always #5 clk = ~clk;

  assign y_s[0] = tbl[0][{a_s[0], b_s[0]}];
  assign y_s[1] = tbl[1][{a_s[1], b_s[1]}];

  gate_bist_ctrl #(.SETTLE(S0), .TRUTH(T0)) u_nxor (
    .CLK(clk), .N_RESET(n_reset), .START(start), .ABORT(abort), .Y(y_s[0]),
    .A(a_s[0]), .B(b_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]), .PASS(pass_s[0]),
    .ERR_CNT(err_s[0]), .FAIL_VEC(fv_s[0])
  );

  gate_bist_ctrl #(.SETTLE(S1), .TRUTH(T1)) u_xor (
    .CLK(clk), .N_RESET(n_reset), .START(start), .ABORT(abort), .Y(y_s[1]),
    .A(a_s[1]), .B(b_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]), .PASS(pass_s[1]),
    .ERR_CNT(err_s[1]), .FAIL_VEC(fv_s[1])
  );

  function automatic int s_of(int g);
    return (g == 0) ? S0 : S1;
  endfunction

  function automatic logic [3:0] t_of(int g);
    return (g == 0) ? T0 : T1;
  endfunction

  function automatic void q_push(int g, done_t e);
    if (g == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic done_t q_pop(int g);
    if (g == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int q_size(int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_due(int g);
    return (g == 0) ? q0[0].due : q1[0].due;
  endfunction

  function automatic void q_clear(int g);
    if (g == 0) q0.delete(); else q1.delete();
  endfunction

  // Reference model: run timing derived from edge numbers relative to the START edge.
  initial begin : model
    int         rel, v, s, len;
    logic [3:0] t, mism;
    done_t      e;
    for (int g = 0; g < 2; g++) begin
      act[g] = 0; st[g] = 0; run_tbl[g] = '0; m_ab[g] = '0; m_busy[g] = 0;
      m_pass[g] = 0; m_err[g] = '0; m_fv[g] = '0;
    end
    forever begin
      @(posedge clk);
      ecnt++;
      for (int g = 0; g < 2; g++) begin
        s   = s_of(g);
        len = 4 * (s + 2);
        t   = t_of(g);
        if (!n_reset) begin
          act[g] = 0; q_clear(g);
          m_ab[g] = '0; m_busy[g] = 0; m_pass[g] = 0; m_err[g] = '0; m_fv[g] = '0;
        end else if (act[g]) begin
          rel = ecnt - st[g];
          if (abort) begin
            act[g] = 0; m_busy[g] = 0; m_ab[g] = '0; m_pass[g] = 0; q_clear(g);
          end else if (rel == len + 1) begin
            act[g] = 0; m_busy[g] = 0; m_ab[g] = '0; m_pass[g] = (m_err[g] == 3'd0);
          end else if (rel % (s + 2) == 0) begin
            v = rel / (s + 2) - 1;
            if (run_tbl[g][v] != t[v]) begin
              m_err[g]   = m_err[g] + 3'd1;
              m_fv[g][v] = 1'b1;
            end
            if (v < 3) m_ab[g] = 2'(v + 1);
          end
        end else if (start) begin
          act[g] = 1; st[g] = ecnt; run_tbl[g] = tbl[g];
          m_busy[g] = 1; m_ab[g] = '0; m_pass[g] = 0; m_err[g] = '0; m_fv[g] = '0;
          mism  = tbl[g] ^ t;
          e.due = ecnt + len;
          e.err = 3'($countones(mism));
          e.fv  = mism;
          q_push(g, e);
        end
      end
    end
  end

  initial begin : monitor
    logic [10:0] got, exp;
    done_t       e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        got = {a_s[g], b_s[g], busy_s[g], pass_s[g], err_s[g], fv_s[g]};
        exp = {m_ab[g], m_busy[g], m_pass[g], m_err[g], m_fv[g]};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL state inst=%0d edge=%0d {ab,busy,pass,err,fv} got=%h want=%h", g, ecnt, got, exp);
        end
        if (done_s[g] === 1'b1) begin
          checks++;
          if (q_size(g) == 0) begin
            failures++;
            $display("FAIL unexpected_done inst=%0d edge=%0d", g, ecnt);
          end else begin
            e = q_pop(g);
            if (e.due != ecnt) begin
              failures++;
              $display("FAIL done_time inst=%0d got_edge=%0d want_edge=%0d", g, ecnt, e.due);
            end
            checks++;
            if (err_s[g] !== e.err || fv_s[g] !== e.fv) begin
              failures++;
              $display("FAIL done_result inst=%0d err got=%0d want=%0d fv got=%b want=%b",
                       g, err_s[g], e.err, fv_s[g], e.fv);
            end
          end
        end else if (q_size(g) > 0 && q_due(g) <= ecnt) begin
          checks++;
          failures++;
          $display("FAIL done_missing inst=%0d edge=%0d want_edge=%0d", g, ecnt, q_due(g));
          void'(q_pop(g));
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((act[0] || act[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (act[0] || act[1]) begin
      failures++;
      $display("FAIL idle_timeout busy_model=%0d%0d want=00", act[0], act[1]);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : driver
    int r;
    n_reset = 1'b0; start = 1'b1; abort = 1'b0;
    tbl[0] = T0; tbl[1] = T1;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200);

    tbl[0] = 4'b1111; tbl[1] = 4'b1111;
    pulse_start();
    wait_idle(200);

    tbl[0] = T0; tbl[1] = T1;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_idle(200);

    tbl[0] = 4'b1011;
    pulse_start();
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(200);

    tbl[0] = T0;
    pulse_start();
    repeat (5) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(200);

    for (int it = 0; it < 24; it++) begin
      for (int g = 0; g < 2; g++)
        tbl[g] = ($urandom_range(0, 3) == 0) ? t_of(g) : 4'($urandom_range(0, 15));
      pulse_start();
      for (int c = 0; c < L0 + 4; c++) begin
        r = int'($urandom_range(0, 99));
        start   = (r < 4);
        abort   = (r >= 4 && r < 6);
        n_reset = (r != 6);
        @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; n_reset = 1'b1;
      wait_idle(200);
    end

    tbl[0] = 4'b0001; tbl[1] = T1;
    start = 1'b1;
    repeat (3 * (L0 + 2) + 5) @(negedge clk);
    start = 1'b0;
    wait_idle(200);

    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL pending_done got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
